// File: rtl/regfile_port_arbiter.sv
// Two-requester round-robin front end for a shared 2R1W register file.
// Read data is tagged to its requester and bypassed from same-cycle writes.
module regfile_port_arbiter #(
  parameter int ADDR_BIT_NUM = 5,
  parameter int RV_BIT_NUM   = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                rd_req,
  input  logic [2*ADDR_BIT_NUM-1:0] rd_rs1_addr,
  input  logic [2*ADDR_BIT_NUM-1:0] rd_rs2_addr,
  output logic [1:0]                rd_gnt,
  output logic [1:0]                rd_valid,
  output logic [RV_BIT_NUM-1:0]     rd_rs1_data,
  output logic [RV_BIT_NUM-1:0]     rd_rs2_data,
  input  logic [1:0]                wr_req,
  input  logic [2*ADDR_BIT_NUM-1:0] wr_addr,
  input  logic [2*RV_BIT_NUM-1:0]   wr_data,
  output logic [1:0]                wr_gnt,
  output logic [ADDR_BIT_NUM-1:0]   rf_rs1_addr,
  output logic [ADDR_BIT_NUM-1:0]   rf_rs2_addr,
  input  logic [RV_BIT_NUM-1:0]     rf_rs1_data,
  input  logic [RV_BIT_NUM-1:0]     rf_rs2_data,
  output logic [ADDR_BIT_NUM-1:0]   rf_waddr,
  output logic [RV_BIT_NUM-1:0]     rf_wdata,
  output logic                      rf_wen
);

  localparam int AW = ADDR_BIT_NUM;
  localparam int DW = RV_BIT_NUM;

  // ptr = 0 -> requester 0 has priority on a tie
  logic          rd_ptr_q;
  logic          rd_ptr_d;
  logic          wr_ptr_q;
  logic          wr_ptr_d;
  logic [1:0]    rd_valid_q;
  logic [1:0]    rd_valid_d;
  logic          byp1_q;
  logic          byp1_d;
  logic          byp2_q;
  logic          byp2_d;
  logic [DW-1:0] byp_data_q;
  logic [DW-1:0] byp_data_d;

  function automatic logic [1:0] rr_pick(
    input logic [1:0] req,
    input logic       ptr
  );
    logic [1:0] g;
    g[0] = req[0] & (~req[1] | ~ptr);
    g[1] = req[1] & (~req[0] |  ptr);
    return g;
  endfunction

  always_comb begin
    rd_gnt = rr_pick(rd_req, rd_ptr_q);
    wr_gnt = rr_pick(wr_req, wr_ptr_q);
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (|rd_gnt) rd_ptr_d = rd_gnt[0];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (|wr_gnt) wr_ptr_d = wr_gnt[0];
  end

  always_comb begin
    rf_rs1_addr = rd_rs1_addr[0 +: AW];
    rf_rs2_addr = rd_rs2_addr[0 +: AW];
    unique case (1'b1)
      rd_gnt[1]: begin
        rf_rs1_addr = rd_rs1_addr[AW +: AW];
        rf_rs2_addr = rd_rs2_addr[AW +: AW];
      end
      default: ;
    endcase
  end

  always_comb begin
    rf_waddr = wr_addr[0 +: AW];
    rf_wdata = wr_data[0 +: DW];
    unique case (1'b1)
      wr_gnt[1]: begin
        rf_waddr = wr_addr[AW +: AW];
        rf_wdata = wr_data[DW +: DW];
      end
      default: ;
    endcase
  end

  assign rf_wen = |wr_gnt;

  // RAM returns stale data on read-during-write; x0 is never bypassed
  always_comb begin
    rd_valid_d = rd_gnt;
    byp1_d     = rf_wen && (rf_waddr == rf_rs1_addr)
                 && (rf_waddr != '0);
    byp2_d     = rf_wen && (rf_waddr == rf_rs2_addr)
                 && (rf_waddr != '0);
    byp_data_d = rf_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_valid_q <= 2'b00;
      byp1_q     <= 1'b0;
      byp2_q     <= 1'b0;
      byp_data_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_valid_q <= rd_valid_d;
      byp1_q     <= byp1_d;
      byp2_q     <= byp2_d;
      byp_data_q <= byp_data_d;
    end
  end

  always_comb begin
    rd_valid    = rd_valid_q;
    rd_rs1_data = byp1_q ? byp_data_q : rf_rs1_data;
    rd_rs2_data = byp2_q ? byp_data_q : rf_rs2_data;
  end

endmodule
